// File: rtl/fp_inflight_pipe.sv
// fp_inflight_pipe
//   In-flight tracking pipeline for multi-cycle FP execution units. Carries
//   each instruction's destination tag, write enables and an opaque payload
//   through DEPTH stages in step with the arithmetic datapath. It exposes the
//   per-stage hazard vectors, answers three source-register busy queries, and
//   can optionally collapse bubbles while the output is stalled.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                advance enable (0 = downstream stall)
//   clear[DEPTH]      per-stage squash of the value written into stage k
//   in_*              instruction presented at stage 0; in_ready = accepted
//   out_*             contents of stage DEPTH-1
//   uu_rd/uu_reg_write/uu_FP_reg_write  per-stage destination / write flags
//   src_addr/src_fp   three hazard queries; src_busy/src_dist answers
//   occupancy         number of valid stages
module fp_inflight_pipe #(
  parameter int DEPTH     = 6,
  parameter int ADDR_W    = 5,
  parameter int PAYLOAD_W = 32,
  parameter int COMPRESS  = 0,
  localparam int DW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DEPTH-1:0]          clear,
  input  logic                      in_valid,
  input  logic [ADDR_W-1:0]         in_rd,
  input  logic                      in_reg_write,
  input  logic                      in_fp_reg_write,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_rd,
  output logic                      out_reg_write,
  output logic                      out_fp_reg_write,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DEPTH*ADDR_W-1:0]   uu_rd,
  output logic [DEPTH-1:0]          uu_reg_write,
  output logic [DEPTH-1:0]          uu_FP_reg_write,
  input  logic [3*ADDR_W-1:0]       src_addr,
  input  logic [2:0]                src_fp,
  output logic [2:0]                src_busy,
  output logic [3*DW-1:0]           src_dist,
  output logic [OW-1:0]             occupancy
);

  typedef struct packed {
    logic                 v;
    logic [ADDR_W-1:0]    rd;
    logic                 rw;
    logic                 fw;
    logic [PAYLOAD_W-1:0] pl;
  } stage_t;

  localparam logic CMP = (COMPRESS != 0);

  stage_t [DEPTH-1:0] st;
  stage_t [DEPTH-1:0] nxt;
  logic   [DEPTH-1:0] adv;

  // Advance decisions use start-of-cycle occupancy only, so a hole moves at
  // most one slot per cycle when collapsing.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH - 1; k++) adv[k] = en | (CMP & ~st[k+1].v);
    adv[DEPTH-1] = en;
  end

  assign in_ready = en | (CMP & ~st[0].v);

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        always_comb begin
          nxt[0] = st[0];
          if (clear[0])      nxt[0] = '0;
          else if (in_ready) nxt[0] = in_valid ?
                               '{v: 1'b1, rd: in_rd, rw: in_reg_write,
                                 fw: in_fp_reg_write, pl: in_payload} : '0;
        end
      end else begin : g_body
        // Upstream arrival (even a bubble) beats a drain; a drain with nothing
        // arriving leaves a bubble so invalid stages stay all-zero.
        always_comb begin
          nxt[k] = st[k];
          if (clear[k])        nxt[k] = '0;
          else if (adv[k-1])   nxt[k] = st[k-1];
          else if (adv[k])     nxt[k] = '0;
        end
      end

      assign uu_rd[k*ADDR_W +: ADDR_W] = st[k].rd;
      assign uu_reg_write[k]           = st[k].v & st[k].rw;
      assign uu_FP_reg_write[k]        = st[k].v & st[k].fw;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) st <= '0;
    else     st <= nxt;
  end

  assign out_valid        = st[DEPTH-1].v;
  assign out_rd           = st[DEPTH-1].rd;
  assign out_reg_write    = st[DEPTH-1].rw;
  assign out_fp_reg_write = st[DEPTH-1].fw;
  assign out_payload      = st[DEPTH-1].pl;

  // Scan from the oldest stage down so the youngest match is written last.
  always_comb begin
    src_busy = '0;
    src_dist = '0;
    for (int q = 0; q < 3; q++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (st[s].v && st[s].rd == src_addr[q*ADDR_W +: ADDR_W] &&
            ((src_fp[q] && st[s].fw) ||
             (!src_fp[q] && st[s].rw && src_addr[q*ADDR_W +: ADDR_W] != '0))) begin
          src_busy[q]           = 1'b1;
          src_dist[q*DW +: DW]  = DW'(s);
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < DEPTH; s++) occupancy = occupancy + OW'(st[s].v);
  end

endmodule

// File: tb/tb_fp_inflight_pipe.sv
// Directed bench for fp_inflight_pipe: one instance without and one with
// bubble collapse, both DEPTH=6, driven by the same stimulus.
module tb_fp_inflight_pipe;
  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_reg_write, in_fp_reg_write;
  logic [5:0]  clear;
  logic [4:0]  in_rd;
  logic [31:0] in_payload;
  logic [14:0] src_addr;
  logic [2:0]  src_fp;

  logic        in_ready, out_valid, out_rw, out_fw;
  logic [4:0]  out_rd;
  logic [31:0] out_payload;
  logic [29:0] uu_rd;
  logic [5:0]  uu_rw, uu_fw;
  logic [2:0]  src_busy, occ;
  logic [8:0]  src_dist;

  logic        in_ready_c, out_valid_c, out_rw_c, out_fw_c;
  logic [4:0]  out_rd_c;
  logic [31:0] out_payload_c;
  logic [29:0] uu_rd_c;
  logic [5:0]  uu_rw_c, uu_fw_c;
  logic [2:0]  src_busy_c, occ_c;
  logic [8:0]  src_dist_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_inflight_pipe #(.DEPTH(6), .ADDR_W(5), .PAYLOAD_W(32), .COMPRESS(0)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(in_valid),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_fp_reg_write(in_fp_reg_write),
    .in_payload(in_payload), .in_ready(in_ready), .out_valid(out_valid),
    .out_rd(out_rd), .out_reg_write(out_rw), .out_fp_reg_write(out_fw),
    .out_payload(out_payload), .uu_rd(uu_rd), .uu_reg_write(uu_rw),
    .uu_FP_reg_write(uu_fw), .src_addr(src_addr), .src_fp(src_fp),
    .src_busy(src_busy), .src_dist(src_dist), .occupancy(occ));

  fp_inflight_pipe #(.DEPTH(6), .ADDR_W(5), .PAYLOAD_W(32), .COMPRESS(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(in_valid),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_fp_reg_write(in_fp_reg_write),
    .in_payload(in_payload), .in_ready(in_ready_c), .out_valid(out_valid_c),
    .out_rd(out_rd_c), .out_reg_write(out_rw_c), .out_fp_reg_write(out_fw_c),
    .out_payload(out_payload_c), .uu_rd(uu_rd_c), .uu_reg_write(uu_rw_c),
    .uu_FP_reg_write(uu_fw_c), .src_addr(src_addr), .src_fp(src_fp),
    .src_busy(src_busy_c), .src_dist(src_dist_c), .occupancy(occ_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic fw,
                      input logic [31:0] pl);
    in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_fp_reg_write = fw;
    in_payload = pl;
    tick();
    in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_fp_reg_write = 1'b0;
    in_payload = '0;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; clear = '0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; clear = '0; in_valid = 1'b0; in_rd = '0;
    in_reg_write = 1'b0; in_fp_reg_write = 1'b0; in_payload = '0;
    src_addr = '0; src_fp = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got %0d want 0", occ); end
    total++; if (uu_rd !== 30'd0 || uu_fw !== 6'd0 || uu_rw !== 6'd0) begin bad++; $display("FAIL reset_uu got %0h/%0h/%0h want 0", uu_rd, uu_fw, uu_rw); end
    total++; if (out_payload !== 32'd0) begin bad++; $display("FAIL reset_payload got %0h want 0", out_payload); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
  endtask

  task automatic test_fill_drain;
    logic [5:0] fw_exp [1:8];
    logic [2:0] occ_exp [1:8];
    fw_exp  = '{6'b000001, 6'b000011, 6'b000111, 6'b001110,
                6'b011100, 6'b111000, 6'b110000, 6'b100000};
    occ_exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1};
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      if (k <= 3) push(5'(2 + k), 1'b0, 1'b1, 32'hA0 + 32'(k));
      else idle();
      total++; if (uu_fw !== fw_exp[k]) begin bad++; $display("FAIL fill_uu_fw[%0d] got %b want %b", k, uu_fw, fw_exp[k]); end
      total++; if (occ !== occ_exp[k]) begin bad++; $display("FAIL fill_occ[%0d] got %0d want %0d", k, occ, occ_exp[k]); end
      total++; if (uu_rw !== 6'd0) begin bad++; $display("FAIL fill_uu_rw[%0d] got %b want 0", k, uu_rw); end
      if (k >= 6) begin
        total++; if (out_valid !== 1'b1 || out_rd !== 5'(k - 3)) begin bad++; $display("FAIL fill_out_rd[%0d] got v=%0h rd=%0d want v=1 rd=%0d", k, out_valid, out_rd, k - 3); end
        total++; if (out_payload !== 32'hA0 + 32'(k - 5) || out_fw !== 1'b1) begin bad++; $display("FAIL fill_out_pl[%0d] got %0h fw=%0h want %0h fw=1", k, out_payload, out_fw, 32'hA0 + 32'(k - 5)); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_out_early[%0d] got %0h want 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_stall;
    logic [29:0] rd_hold, rd_c1, rd_c3;
    rd_hold = '0; rd_hold[4*5 +: 5] = 5'd9; rd_hold[1*5 +: 5] = 5'd6;
    rd_c1   = '0; rd_c1[5*5 +: 5]   = 5'd9; rd_c1[2*5 +: 5]   = 5'd6;
    rd_c3   = '0; rd_c3[5*5 +: 5]   = 5'd9; rd_c3[4*5 +: 5]   = 5'd6;
    do_reset();
    push(5'd9, 1'b0, 1'b1, 32'h900D); idle(); idle();
    push(5'd6, 1'b0, 1'b1, 32'h600D); idle();
    total++; if (uu_fw !== 6'b010010 || uu_rd !== rd_hold) begin bad++; $display("FAIL stall_setup got %b %0h want 010010 %0h", uu_fw, uu_rd, rd_hold); end
    en = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %0h want 0", in_ready); end
    total++; if (in_ready_c !== 1'b1) begin bad++; $display("FAIL stall_c_in_ready got %0h want 1", in_ready_c); end
    tick();
    total++; if (uu_fw_c !== 6'b100100 || uu_rd_c !== rd_c1) begin bad++; $display("FAIL compress_1 got %b %0h want 100100 %0h", uu_fw_c, uu_rd_c, rd_c1); end
    total++; if (out_valid_c !== 1'b1 || out_rd_c !== 5'd9 || out_payload_c !== 32'h900D) begin bad++; $display("FAIL compress_out1 got v=%0h rd=%0d pl=%0h want 1 9 900d", out_valid_c, out_rd_c, out_payload_c); end
    tick(); tick();
    total++; if (uu_fw !== 6'b010010 || uu_rd !== rd_hold || occ !== 3'd2) begin bad++; $display("FAIL stall_hold got %b %0h occ=%0d want 010010 %0h 2", uu_fw, uu_rd, occ, rd_hold); end
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_hold_io got rdy=%0h ov=%0h want 0 0", in_ready, out_valid); end
    total++; if (uu_fw_c !== 6'b110000 || uu_rd_c !== rd_c3) begin bad++; $display("FAIL compress_3 got %b %0h want 110000 %0h", uu_fw_c, uu_rd_c, rd_c3); end
    total++; if (out_rd_c !== 5'd9 || out_payload_c !== 32'h900D || in_ready_c !== 1'b1) begin bad++; $display("FAIL compress_out3 got rd=%0d pl=%0h rdy=%0h want 9 900d 1", out_rd_c, out_payload_c, in_ready_c); end
    tick();
    total++; if (uu_fw_c !== 6'b110000 || uu_rd_c !== rd_c3) begin bad++; $display("FAIL compress_frozen got %b %0h want 110000 %0h", uu_fw_c, uu_rd_c, rd_c3); end
    en = 1'b1;
  endtask

  task automatic test_clear;
    logic [29:0] rd_exp;
    rd_exp = '0; rd_exp[3*5 +: 5] = 5'd2; rd_exp[4*5 +: 5] = 5'd1;
    do_reset();
    push(5'd1, 1'b0, 1'b1, 32'h1); push(5'd2, 1'b0, 1'b1, 32'h2);
    push(5'd3, 1'b0, 1'b1, 32'h3); idle();
    total++; if (uu_fw !== 6'b001110) begin bad++; $display("FAIL clear_setup got %b want 001110", uu_fw); end
    clear = 6'b000100;
    idle();
    clear = '0;
    total++; if (uu_fw !== 6'b011000 || uu_rd !== rd_exp) begin bad++; $display("FAIL clear_prio got %b %0h want 011000 %0h", uu_fw, uu_rd, rd_exp); end
    total++; if (occ !== 3'd2) begin bad++; $display("FAIL clear_occ got %0d want 2", occ); end
  endtask

  task automatic test_hazard;
    do_reset();
    push(5'd7, 1'b0, 1'b1, 32'h70); idle();
    push(5'd0, 1'b1, 1'b0, 32'h00); push(5'd7, 1'b0, 1'b1, 32'h71); idle();
    src_addr = {5'd0, 5'd7, 5'd7};
    src_fp   = 3'b001;
    #1;
    total++; if (src_busy !== 3'b001) begin bad++; $display("FAIL hazard_busy got %b want 001", src_busy); end
    total++; if (src_dist !== 9'b000_000_001) begin bad++; $display("FAIL hazard_dist got %b want 000000001", src_dist); end
    total++; if (occ !== 3'd3 || uu_rw !== 6'b000100) begin bad++; $display("FAIL hazard_state got occ=%0d rw=%b want 3 000100", occ, uu_rw); end
    idle();
    total++; if (src_busy !== 3'b001 || src_dist !== 9'b000_000_010) begin bad++; $display("FAIL hazard_dist2 got %b %b want 001 000000010", src_busy, src_dist); end
    src_addr = '0; src_fp = '0;
  endtask

  task automatic test_clear_all;
    do_reset();
    push(5'd4, 1'b1, 1'b0, 32'h4); push(5'd5, 1'b0, 1'b1, 32'h5);
    in_valid = 1'b1; in_rd = 5'd8; in_fp_reg_write = 1'b1; in_payload = 32'h8;
    clear = '1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clear_all_rdy got %0h want 1", in_ready); end
    tick();
    clear = '0; in_valid = 1'b0; in_fp_reg_write = 1'b0;
    total++; if (occ !== 3'd0 || occ_c !== 3'd0 || uu_rd !== 30'd0) begin bad++; $display("FAIL clear_all got occ=%0d occ_c=%0d rd=%0h want 0 0 0", occ, occ_c, uu_rd); end
  endtask

  task automatic test_reset_full;
    do_reset();
    for (int i = 0; i < 6; i++) push(5'(10 + i), 1'b1, 1'b0, 32'(i));
    total++; if (occ !== 3'd6 || uu_rw !== 6'b111111) begin bad++; $display("FAIL full_setup got occ=%0d rw=%b want 6 111111", occ, uu_rw); end
    rst = 1'b1; in_valid = 1'b1; in_rd = 5'd20; in_fp_reg_write = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_fp_reg_write = 1'b0;
    total++; if (occ !== 3'd0 || out_valid !== 1'b0 || uu_rd !== 30'd0 || out_payload !== 32'd0 || out_rd !== 5'd0) begin bad++; $display("FAIL reset_full got occ=%0d ov=%0h rd=%0h pl=%0h want all 0", occ, out_valid, uu_rd, out_payload); end
    push(5'd12, 1'b0, 1'b1, 32'hC0DE);
    for (int i = 0; i < 4; i++) idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_early got %0h want 0", out_valid); end
    idle();
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd12 || out_payload !== 32'hC0DE) begin bad++; $display("FAIL post_reset_out got v=%0h rd=%0d pl=%0h want 1 12 c0de", out_valid, out_rd, out_payload); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stall();
    test_clear();
    test_hazard();
    test_clear_all();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
